pool_row_feeder: RTL and testbench



---
 rtl/pool_row_feeder.sv | 90 +++++++++
 tb/tb_pool_row_feeder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pool_row_feeder.sv
//------------------------------------------------------------------------------
// pool_row_feeder: buffers each even row and streams vertically aligned pixel
// pairs (even-row, odd-row) to the 2x2 pooling kernel.   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pool_row_feeder #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              clear,
  output logic [DATA_W-1:0] d_out1,
  output logic [DATA_W-1:0] d_out2,
  output logic              out_valid,
  output logic              out_row_end,
  output logic              frame_done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] line_buf [IMG_W];

  logic              accept;
  logic              last_col;
  logic              last_row;
  logic              odd_row;
  logic [DATA_W-1:0] upper_pix;

  assign accept    = s_valid & ~clear;
  assign last_col  = (col == COL_LAST);
  assign last_row  = (row == ROW_LAST);
  assign odd_row   = row[0];
  assign upper_pix = line_buf[col];

  // Frame position; clear outranks a valid pixel in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (s_valid) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffer holds no reset state; only even rows write it.
  always_ff @(posedge clk) begin
    if (accept && !odd_row) begin
      line_buf[col] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out1      <= '0;
      d_out2      <= '0;
      out_valid   <= 1'b0;
      out_row_end <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      out_valid   <= accept & odd_row;
      out_row_end <= accept & odd_row & last_col;
      frame_done  <= accept & last_row & last_col;
      if (accept && odd_row) begin
        d_out1 <= upper_pix;
        d_out2 <= s_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pool_row_feeder.sv
//------------------------------------------------------------------------------
// tb_pool_row_feeder: table-driven directed bench for pool_row_feeder (4x4).
//------------------------------------------------------------------------------
`default_nettype none

module tb_pool_row_feeder;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct {
    logic          v;
    logic          c;
    logic [DW-1:0] d;
    logic          ev;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    logic          ere;
    logic          efd;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] d_out1, d_out2;
  logic          out_valid, out_row_end, frame_done;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  logic [DW-1:0] hold1 = '0;
  logic [DW-1:0] hold2 = '0;

  pool_row_feeder #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .clear      (clear),
    .d_out1     (d_out1),
    .d_out2     (d_out2),
    .out_valid  (out_valid),
    .out_row_end(out_row_end),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  // Expected data on idle cycles is the last pair, since outputs hold.
  task automatic push(input logic v, input logic c, input logic [DW-1:0] d, input logic ev,
                      input logic [DW-1:0] e1, input logic [DW-1:0] e2, input logic ere, input logic efd);
    vec_t t;
    if (ev) begin
      hold1 = e1;
      hold2 = e2;
    end
    t.v = v; t.c = c; t.d = d; t.ev = ev;
    t.e1 = hold1; t.e2 = hold2; t.ere = ere; t.efd = efd;
    tbl.push_back(t);
  endtask

  // Pixel p (0..15) of a 4x4 frame whose pixel values are base+p.
  task automatic push_pix(input int p, input logic [DW-1:0] base);
    int r;
    int cc;
    r  = p / W;
    cc = p % W;
    if (r % 2 == 1)
      push(1'b1, 1'b0, base + DW'(p), 1'b1, base + DW'(p - W), base + DW'(p),
           cc == W - 1, p == W * H - 1);
    else
      push(1'b1, 1'b0, base + DW'(p), 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic push_idle();
    push(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      s_valid = tbl[i].v;
      clear   = tbl[i].c;
      s_data  = tbl[i].d;
      @(posedge clk);
      #1;
      chk({nm, ".valid"},   i, DW'(out_valid),   DW'(tbl[i].ev));
      chk({nm, ".row_end"}, i, DW'(out_row_end), DW'(tbl[i].ere));
      chk({nm, ".fdone"},   i, DW'(frame_done),  DW'(tbl[i].efd));
      chk({nm, ".d1"},      i, d_out1,           tbl[i].e1);
      chk({nm, ".d2"},      i, d_out2,           tbl[i].e2);
    end
    s_valid = 1'b0;
    clear   = 1'b0;
    tbl.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".valid"},   0, DW'(out_valid),   '0);
    chk({nm, ".row_end"}, 0, DW'(out_row_end), '0);
    chk({nm, ".fdone"},   0, DW'(frame_done),  '0);
    chk({nm, ".d1"},      0, d_out1,           '0);
    chk({nm, ".d2"},      0, d_out2,           '0);
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int p = 0; p < 16; p++) push_pix(p, 0);
    run_table("sustained");

    for (int p = 0; p < 16; p++) begin
      push_pix(p, 0);
      push_idle();
    end
    run_table("gapped");

    for (int p = 0; p < 16; p++) push_pix(p, 0);
    for (int p = 0; p < 16; p++) push_pix(p, 16);
    run_table("b2b");

    for (int p = 0; p < 6; p++) push_pix(p, 0);
    push(1'b1, 1'b1, 32'd6, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int p = 0; p < 16; p++) push_pix(p, 100);
    run_table("clear");

    for (int p = 0; p < 4; p++) push_pix(p, 0);
    push(1'b1, 1'b1, 32'd99, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int p = 0; p < 4; p++) push_pix(p, 8);
    push(1'b0, 1'b1, 32'd0, 1'b0, '0, '0, 1'b0, 1'b0);
    run_table("evensilent");

    // Async reset right after the pair for pixel 5 appears.
    for (int p = 0; p < 6; p++) push_pix(p, 0);
    run_table("prereset");
    #2;
    rst = 1'b1;
    #1;
    chk_zero("asyncrst");
    @(negedge clk);
    rst = 1'b0;
    hold1 = '0;
    hold2 = '0;

    for (int p = 0; p < 16; p++) push_pix(p, 0);
    run_table("postreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
